// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (receiver state encoding, oversampling rate, frame defaults).
// Latency: n/a, declarations only.
// Backpressure: n/a.
package uart_pkg;

    // Ticks per bit period produced by the shared baud-rate generator.
    localparam int OVERSAMPLE  = 16;

    // Frame defaults shared by the transmitter, receiver and baud generator.
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

    // One-hot receiver state encoding.
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        STOP  = 5'b01000,
        BREAK = 5'b10000
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for a single asynchronous input, with a selectable reset level.
// Latency: 2 clk from input change to output change.
// Backpressure: none, free-running.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Purpose: 16x oversampled UART receiver, LSB-first DBIT-bit frames, framing-error and break handling.
// Latency: rx_done_tick one clk after the stop-bit sampling tick (start + 8 + 16*DBIT + SB_TICK ticks).
// Backpressure: none; each frame is a single-cycle pulse the consumer (receive FIFO) must absorb.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    // Tick counter must reach both the 16-tick bit period and the stop length.
    localparam int SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    rx_state_t       state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            rx_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM, counters, shift register and registered outputs, all advancing on s_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            if (s_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            s     <= '0;
                        end
                    end
                    START: begin
                        // Re-check the line at mid start bit; high here means a glitch.
                        if (s == S_HALF) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    DATA: begin
                        // From mid start bit, every 16th tick lands at a data bit centre.
                        if (s == S_BIT) begin
                            b <= {rx_s, b[DBIT-1:1]};
                            s <= '0;
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    STOP: begin
                        if (s == S_STOP) begin
                            dout         <= b;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                            // A low stop bit may be a break; wait for the line to go high again.
                            state        <= rx_s ? IDLE : BREAK;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the counterpart of the transmit stage on the far end of the serial line. It oversamples `rx` using the shared baud-rate generator's `s_tick` (16 ticks per bit) and recovers DBIT-bit LSB-first frames. It presents each byte on `dout` with a one-clock `rx_done_tick`, which writes the receive FIFO. It flags framing errors and suppresses false starts caused by glitches or a line held in break.

## Interface
- `DBIT`, 8, data bits per frame (2..16)
- `SB_TICK`, 16, `s_tick` count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `s_tick`  in  1  oversampling enable, one `clk` wide, 16 per bit period
- `rx`  in  1  asynchronous serial input, idle high
- `dout`  out  DBIT  last received data word, LSB = first bit on line
- `rx_done_tick`  out  1  one-`clk` pulse: `dout`/`frame_err` just updated
- `frame_err`  out  1  stop bit of last frame sampled low; valid with and held after `rx_done_tick`

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) before any use; `rx_s` denotes its output.
- State, counters and shift register advance only in cycles where `s_tick`=1. `rx_done_tick` is a registered output. It is cleared every `clk` in which it is not being set.
- Counters: `s` counts ticks, width clog2(max(16,SB_TICK)). `n` counts bits, width clog2(DBIT). Both are unsigned and reset each phase, and never wrap in normal flow.
- States:
  - IDLE: on a tick with `rx_s`=0 → START, `s`=0.
  - START: on a tick, if `s`==7: when `rx_s`=0 → DATA with `s`=0, `n`=0; when `rx_s`=1 it is a glitch → IDLE. Otherwise `s`++.
  - DATA: on a tick, if `s`==15: `b` = {`rx_s`, `b`[DBIT-1:1]}, `s`=0, then → STOP when `n`==DBIT-1, else `n`++. Otherwise `s`++.
  - STOP: on a tick, if `s`==SB_TICK-1: `dout`=`b`, `frame_err`=~`rx_s`, `rx_done_tick`=1. Then → IDLE when `rx_s`=1, or → BREAK when `rx_s`=0. Otherwise `s`++.
  - BREAK: on a tick with `rx_s`=1 → IDLE. A low line never starts a frame from here.
- Reset values: state IDLE, `s`=`n`=0, `b`=0, `dout`=0, `rx_done_tick`=0, `frame_err`=0, synchronizer flops 1.
- Reset asserted mid-frame: immediate abort, no `rx_done_tick`, `dout` cleared.
- Frame with framing error still delivers `dout` and pulses `rx_done_tick`. The consumer decides whether to discard it.

## Timing
- Start detection tick T0 is the first tick after `rx` low has crossed the synchronizer. That adds 2 `clk` of latency before the line change can be seen.
- START exits at T8, so later samples land at bit-centre.
- Data bit k is sampled at T(24+16k).
- Stop is sampled and `rx_done_tick` is raised at T(8+16·DBIT+SB_TICK); that is T152 with the defaults. The pulse is high in the `clk` cycle after that tick edge, for exactly one `clk`.
- The receiver is back in IDLE in time to detect a start bit immediately after a minimum-length stop bit, giving back-to-back frames with no gap.
- A low pulse shorter than 8 ticks is rejected as a glitch. No output changes.
- Ticks absent (`s_tick`=0 indefinitely): the FSM freezes. Only `rx_done_tick` clears.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP, BREAK; one-hot)
  - constant OVERSAMPLE=16
  - default DBIT/SB_TICK shared with the transmitter and baud generator
- Sub-module `sync_2ff`: 2-flop synchronizer with parameterized reset value (1 here). It is reused for other async inputs.
- The rest is a single always block for registers plus next-state logic in the top module.

## Test plan
- Reset, then send 0x55 at 16 ticks/bit, 1 stop bit:
  - `rx_done_tick` pulses once, 152 ticks after start detection
  - `dout`=0x55, `frame_err`=0
- Two back-to-back frames 0xA3, 0x0F with no idle gap → two pulses 160 ticks apart; `dout` 0xA3 then 0x0F.
- 5-tick low glitch on idle line → no `rx_done_tick`; FSM returns to IDLE; a following 0x81 frame is received correctly.
- Frame 0xC4 with stop bit forced low, line then held low 40 bit-times:
  - one pulse with `dout`=0xC4, `frame_err`=1
  - no further pulses until `rx` returns high
  - a subsequent 0x3C frame then gives `frame_err`=0
- Assert `reset` low during data bit 4 of a frame:
  - outputs go to 0 immediately, with no pulse
  - after release, the next full frame 0x7E is received correctly
- DBIT=7, SB_TICK=32, frame 0x5A → pulse at T8+112+32=T152, `dout`=0x5A.
